// File: rtl/mem_req_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_req_if : EX/RDW pipeline handshake and sram-like data bus    |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
interface mem_req_if;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic        ex_flush, ertn_flush, RDW_flush, this_flush;
   logic [31:0] PC, alu_result, store_data, exception_maddr;
   logic [7:0]  mem_op;
   logic        res_from_mem, mem_we, gr_we, has_exception, ertn;
   logic [4:0]  dest;
   logic [5:0]  ecode;
   logic [8:0]  esubcode;
   logic        data_req, data_wr, data_addr_ok, data_ok;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_ok_out, data_valid_from_MEM;
   logic [31:0] data_from_MEM;
   logic [31:0] PC_out, alu_result_out, exception_maddr_out;
   logic [7:0]  mem_op_out;
   logic        res_from_mem_out, gr_we_out, has_exception_out, ertn_out;
   logic [4:0]  dest_out;
   logic [5:0]  ecode_out;
   logic [8:0]  esubcode_out;

   modport slave (
      input  in_valid, out_ready, ex_flush, ertn_flush, RDW_flush,
             PC, alu_result, store_data, mem_op, res_from_mem, mem_we, gr_we, dest,
             has_exception, ecode, esubcode, exception_maddr, ertn,
             data_addr_ok, data_ok, data_rdata,
      output in_ready, out_valid, this_flush,
             data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
             data_ok_out, data_from_MEM, data_valid_from_MEM,
             PC_out, alu_result_out, mem_op_out, res_from_mem_out, gr_we_out, dest_out,
             has_exception_out, ecode_out, esubcode_out, exception_maddr_out, ertn_out
   );

   modport master (
      output in_valid, out_ready, ex_flush, ertn_flush, RDW_flush,
             PC, alu_result, store_data, mem_op, res_from_mem, mem_we, gr_we, dest,
             has_exception, ecode, esubcode, exception_maddr, ertn,
             data_addr_ok, data_ok, data_rdata,
      input  in_ready, out_valid, this_flush,
             data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
             data_ok_out, data_from_MEM, data_valid_from_MEM,
             PC_out, alu_result_out, mem_op_out, res_from_mem_out, gr_we_out, dest_out,
             has_exception_out, ecode_out, esubcode_out, exception_maddr_out, ertn_out
   );
endinterface
`default_nettype wire

// File: rtl/mem_req.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_req : issues load/store requests, detects ALE, filters beats |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_req #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  wire logic  clk,
   input  wire logic  rst,
   mem_req_if.slave   bus
);
   localparam int              c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);
   localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

   logic               w_is_byte, w_is_half, w_is_word, w_need_mem, w_ale, w_flush;
   logic               w_this_flush, w_data_req, w_hs, w_ready_go, w_adv, w_cap, w_dok_cnt;
   logic [3:0]         w_wstrb;
   logic [c_CNT_W-1:0] w_outst_nxt;

   logic [c_CNT_W-1:0] r_outst, r_discard;
   logic               r_req_sent, r_own_pending, r_buf_valid;
   logic [31:0]        r_buf;

   logic               r_out_valid, r_dvalid, r_res_from_mem, r_gr_we, r_has_exc, r_ertn;
   logic [31:0]        r_dfm, r_pc, r_alu, r_maddr;
   logic [7:0]         r_mem_op;
   logic [4:0]         r_dest;
   logic [5:0]         r_ecode;
   logic [8:0]         r_esubcode;

   assign w_is_byte  = bus.mem_op[0] | bus.mem_op[3] | bus.mem_op[5];
   assign w_is_half  = bus.mem_op[1] | bus.mem_op[4] | bus.mem_op[6];
   assign w_is_word  = bus.mem_op[2] | bus.mem_op[7];
   assign w_need_mem = bus.in_valid && (bus.res_from_mem || bus.mem_we);
   assign w_ale      = w_need_mem && ((w_is_half && bus.alu_result[0]) ||
                                      (w_is_word && (bus.alu_result[1:0] != 2'b00)));
   assign w_flush      = bus.ex_flush || bus.ertn_flush;
   assign w_this_flush = bus.in_valid && (bus.has_exception || w_ale || bus.ertn || bus.RDW_flush);
   assign w_data_req   = w_need_mem && !w_this_flush && !r_req_sent && !w_flush &&
                         (r_discard == '0) && (r_outst < c_MAX_OUT);
   assign w_hs       = w_data_req && bus.data_addr_ok;
   assign w_ready_go = !bus.in_valid || w_this_flush || !w_need_mem || r_req_sent || w_hs;
   assign w_adv      = bus.in_valid && w_ready_go && bus.out_ready;
   // A lone beat with only our request in flight must be ours.
   assign w_cap      = bus.data_ok && (r_discard == '0) && r_own_pending && (r_outst == c_ONE);
   assign w_dok_cnt  = bus.data_ok && (r_outst != '0);

   always_comb begin
      w_wstrb = 4'h0;
      if (bus.mem_op[5])      w_wstrb = 4'b0001 << bus.alu_result[1:0];
      else if (bus.mem_op[6]) w_wstrb = 4'b0011 << bus.alu_result[1:0];
      else if (bus.mem_op[7]) w_wstrb = 4'hF;
   end

   always_comb begin
      w_outst_nxt = r_outst;
      if (w_hs && !w_dok_cnt)      w_outst_nxt = r_outst + c_ONE;
      else if (!w_hs && w_dok_cnt) w_outst_nxt = r_outst - c_ONE;
   end

   assign bus.in_ready    = !rst && (!bus.in_valid || (w_ready_go && bus.out_ready));
   assign bus.this_flush  = w_this_flush;
   assign bus.data_req    = w_data_req;
   assign bus.data_wr     = bus.mem_we;
   assign bus.data_size   = w_is_byte ? 2'd0 : (w_is_half ? 2'd1 : 2'd2);
   assign bus.data_wstrb  = w_wstrb;
   assign bus.data_addr   = bus.alu_result;
   assign bus.data_wdata  = bus.mem_op[5] ? {4{bus.store_data[7:0]}} :
                            bus.mem_op[6] ? {2{bus.store_data[15:0]}} : bus.store_data;
   assign bus.data_ok_out = bus.data_ok && (r_discard == '0) && !w_cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outst       <= '0;
         r_discard     <= '0;
         r_req_sent    <= 1'b0;
         r_own_pending <= 1'b0;
         r_buf_valid   <= 1'b0;
         r_buf         <= 32'h0;
      end else begin
         r_outst <= w_outst_nxt;
         // Everything still in flight after this cycle belongs to flushed work.
         if (w_flush)
            r_discard <= w_outst_nxt;
         else if ((r_discard != '0) && bus.data_ok)
            r_discard <= r_discard - c_ONE;
         if (w_flush || w_adv) begin
            r_req_sent    <= 1'b0;
            r_own_pending <= 1'b0;
            r_buf_valid   <= 1'b0;
            r_buf         <= 32'h0;
         end else begin
            if (w_hs) begin
               r_req_sent    <= 1'b1;
               r_own_pending <= 1'b1;
            end
            if (w_cap) begin
               r_own_pending <= 1'b0;
               r_buf_valid   <= 1'b1;
               r_buf         <= bus.data_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;  r_dvalid   <= 1'b0;  r_dfm      <= 32'h0;
         r_pc        <= 32'h0; r_alu      <= 32'h0; r_mem_op   <= 8'h0;
         r_res_from_mem <= 1'b0; r_gr_we  <= 1'b0;  r_dest     <= 5'h0;
         r_has_exc   <= 1'b0;  r_ecode    <= 6'h0;  r_esubcode <= 9'h0;
         r_maddr     <= 32'h0; r_ertn     <= 1'b0;
      end else begin
         if (w_adv) begin
            r_pc           <= bus.PC;
            r_alu          <= bus.alu_result;
            r_mem_op       <= bus.mem_op;
            r_res_from_mem <= bus.res_from_mem;
            r_gr_we        <= bus.gr_we;
            r_dest         <= bus.dest;
            r_has_exc      <= bus.has_exception || w_ale;
            r_ecode        <= w_ale ? 6'h09 : bus.ecode;
            r_esubcode     <= w_ale ? 9'h0 : bus.esubcode;
            r_maddr        <= w_ale ? bus.alu_result : bus.exception_maddr;
            r_ertn         <= bus.ertn;
            r_dfm          <= w_cap ? bus.data_rdata : r_buf;
         end
         if (w_flush) begin
            r_out_valid <= 1'b0;
            r_dvalid    <= 1'b0;
         end else if (bus.out_ready) begin
            r_out_valid <= w_adv;
            r_dvalid    <= w_adv && (r_buf_valid || w_cap);
         end
      end
   end

   assign bus.out_valid           = r_out_valid;
   assign bus.data_valid_from_MEM = r_dvalid;
   assign bus.data_from_MEM       = r_dfm;
   assign bus.PC_out              = r_pc;
   assign bus.alu_result_out      = r_alu;
   assign bus.mem_op_out          = r_mem_op;
   assign bus.res_from_mem_out    = r_res_from_mem;
   assign bus.gr_we_out           = r_gr_we;
   assign bus.dest_out            = r_dest;
   assign bus.has_exception_out   = r_has_exc;
   assign bus.ecode_out           = r_ecode;
   assign bus.esubcode_out        = r_esubcode;
   assign bus.exception_maddr_out = r_maddr;
   assign bus.ertn_out            = r_ertn;
endmodule
`default_nettype wire

// File: tb/tb_mem_req.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_req : directed self-checking bench for mem_req            |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
module tb_mem_req;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   mem_req_if bus();

   mem_req #(.MAX_OUTSTANDING(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      bus.in_valid = 0;  bus.out_ready = 0;  bus.ex_flush = 0; bus.ertn_flush = 0;
      bus.RDW_flush = 0; bus.PC = 0;         bus.alu_result = 0; bus.store_data = 0;
      bus.mem_op = 0;    bus.res_from_mem = 0; bus.mem_we = 0; bus.gr_we = 0;
      bus.dest = 0;      bus.has_exception = 0; bus.ecode = 0; bus.esubcode = 0;
      bus.exception_maddr = 0; bus.ertn = 0; bus.data_addr_ok = 0; bus.data_ok = 0;
      bus.data_rdata = 0;
   endtask

   task automatic ld_w(input logic [31:0] a);
      bus.in_valid = 1; bus.mem_op = 8'h04; bus.res_from_mem = 1; bus.mem_we = 0;
      bus.alu_result = a; bus.PC = 32'h1c00_0000 + a; bus.gr_we = 1; bus.dest = 5'd4;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready",  32'(bus.in_ready), 0);
      chk("rst_pc_out",    bus.PC_out, 0);
      chk("rst_dvalid",    32'(bus.data_valid_from_MEM), 0);

      // ld.w at 0x1000, addr_ok in the second cycle
      @(negedge clk); @(negedge clk);
      rst = 0; bus.out_ready = 1; ld_w(32'h1000);
      #1;
      chk("ldw_req",    32'(bus.data_req), 1);
      chk("ldw_size",   32'(bus.data_size), 2);
      chk("ldw_wstrb",  32'(bus.data_wstrb), 0);
      chk("ldw_wr",     32'(bus.data_wr), 0);
      chk("ldw_addr",   bus.data_addr, 32'h1000);
      chk("ldw_nordy",  32'(bus.in_ready), 0);
      @(negedge clk); bus.data_addr_ok = 1; #1;
      chk("ldw_hs_rdy", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      chk("ldw_ov",     32'(bus.out_valid), 1);
      chk("ldw_pc",     bus.PC_out, 32'h1c00_1000);
      chk("ldw_alu",    bus.alu_result_out, 32'h1000);
      chk("ldw_exc",    32'(bus.has_exception_out), 0);
      chk("ldw_dv",     32'(bus.data_valid_from_MEM), 0);
      @(negedge clk);
      bus.in_valid = 0; bus.data_addr_ok = 0; bus.data_ok = 1; bus.data_rdata = 32'h1111_2222;
      #1;
      chk("ldw_okout",  32'(bus.data_ok_out), 1);

      // st.b / st.h byte lanes and replication
      @(negedge clk);
      bus.data_ok = 0; bus.in_valid = 1; bus.mem_op = 8'h20; bus.mem_we = 1;
      bus.res_from_mem = 0; bus.alu_result = 32'h1003; bus.store_data = 32'h0000_00AB;
      #1;
      chk("stb_wstrb",  32'(bus.data_wstrb), 32'h8);
      chk("stb_wdata",  bus.data_wdata, 32'hABAB_ABAB);
      chk("stb_wr",     32'(bus.data_wr), 1);
      chk("stb_size",   32'(bus.data_size), 0);
      chk("stb_req",    32'(bus.data_req), 1);
      bus.mem_op = 8'h40; bus.alu_result = 32'h1002; bus.store_data = 32'h1234_5678;
      #1;
      chk("sth_wstrb",  32'(bus.data_wstrb), 32'hC);
      chk("sth_wdata",  bus.data_wdata, 32'h5678_5678);
      chk("sth_size",   32'(bus.data_size), 1);

      // ld.h misaligned -> ALE
      @(negedge clk);
      bus.in_valid = 1; bus.mem_op = 8'h02; bus.mem_we = 0; bus.res_from_mem = 1;
      bus.alu_result = 32'h1001; bus.esubcode = 9'h1;
      #1;
      chk("ale_req",    32'(bus.data_req), 0);
      chk("ale_flush",  32'(bus.this_flush), 1);
      chk("ale_rdy",    32'(bus.in_ready), 1);
      @(posedge clk); #1;
      chk("ale_exc",    32'(bus.has_exception_out), 1);
      chk("ale_ecode",  32'(bus.ecode_out), 32'h09);
      chk("ale_esub",   32'(bus.esubcode_out), 0);
      chk("ale_maddr",  bus.exception_maddr_out, 32'h1001);
      chk("ale_ov",     32'(bus.out_valid), 1);

      // ld.w with stalled downstream: own response captured
      @(negedge clk);
      bus.esubcode = 0; ld_w(32'h2000); bus.out_ready = 0; bus.data_addr_ok = 1;
      #1;
      chk("cap_req",    32'(bus.data_req), 1);
      @(negedge clk);
      bus.data_addr_ok = 0; bus.data_ok = 1; bus.data_rdata = 32'hDEAD_BEEF;
      #1;
      chk("cap_okout",  32'(bus.data_ok_out), 0);
      chk("cap_noreq",  32'(bus.data_req), 0);
      chk("cap_stall",  32'(bus.in_ready), 0);
      @(negedge clk);
      bus.data_ok = 0; bus.out_ready = 1;
      #1;
      chk("cap_rdy",    32'(bus.in_ready), 1);
      @(posedge clk); #1;
      chk("cap_data",   bus.data_from_MEM, 32'hDEAD_BEEF);
      chk("cap_dv",     32'(bus.data_valid_from_MEM), 1);
      chk("cap_ov",     32'(bus.out_valid), 1);
      @(negedge clk); bus.in_valid = 0;
      @(posedge clk); #1;
      chk("cap_dv_clr", 32'(bus.data_valid_from_MEM), 0);
      chk("cap_ov_clr", 32'(bus.out_valid), 0);

      // two outstanding, then flush and discard
      @(negedge clk); ld_w(32'h3000); bus.data_addr_ok = 1;
      @(negedge clk); ld_w(32'h3004);
      #1;
      chk("two_req2",   32'(bus.data_req), 1);
      @(negedge clk); ld_w(32'h3008);
      #1;
      chk("full_noreq", 32'(bus.data_req), 0);
      chk("full_nordy", 32'(bus.in_ready), 0);
      bus.in_valid = 0; bus.data_addr_ok = 0; bus.ex_flush = 1;
      @(posedge clk); #1;
      chk("fl_ov",      32'(bus.out_valid), 0);
      @(negedge clk);
      bus.ex_flush = 0; ld_w(32'h3008); bus.data_ok = 1;
      #1;
      chk("dis1_okout", 32'(bus.data_ok_out), 0);
      chk("dis1_noreq", 32'(bus.data_req), 0);
      @(negedge clk); #1;
      chk("dis2_okout", 32'(bus.data_ok_out), 0);
      chk("dis2_noreq", 32'(bus.data_req), 0);
      @(negedge clk); bus.data_ok = 0; #1;
      chk("dis_done",   32'(bus.data_req), 1);

      // reset asserted asynchronously mid-request
      bus.data_addr_ok = 1;
      @(posedge clk); #1;
      chk("pre_ov",     32'(bus.out_valid), 1);
      chk("pre_pc",     bus.PC_out, 32'h1c00_3008);
      @(negedge clk); ld_w(32'h300C);
      #1;
      chk("pre_req",    32'(bus.data_req), 1);
      rst = 1;
      #1;
      chk("arst_ov",    32'(bus.out_valid), 0);
      chk("arst_pc",    bus.PC_out, 0);
      chk("arst_alu",   bus.alu_result_out, 0);
      chk("arst_rdy",   32'(bus.in_ready), 0);
      clr_in();
      @(negedge clk); rst = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mem_req.md
Name: mem_req

Overview:
- Memory-request stage directly upstream of the read-data-wait stage. It receives EX-stage results and issues load/store requests on the sram-like data bus.
- It performs the addr_ok handshake and detects misaligned accesses (ALE).
- If a response arrives for its own request before the instruction advances, it captures the load data and forwards it as data_from_MEM / data_valid_from_MEM.
- It filters data_ok beats that belong to flushed requests, so the downstream stage never sees them.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus requests; width of counters is clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  EX has a valid instruction
- out_ready  in  1  downstream stage can accept
- in_ready  out  1  this stage can accept
- out_valid  out  1  registered valid to downstream
- ex_flush, ertn_flush  in  1 each  pipeline flush from WB
- RDW_flush  in  1  downstream holds a flushing instruction
- this_flush  out  1  this instruction flushes younger work
- PC, alu_result, store_data  in  32 each  PC, effective address, store data
- mem_op  in  8  one-hot: [0]ld.b [1]ld.h [2]ld.w [3]ld.bu [4]ld.hu [5]st.b [6]st.h [7]st.w
- res_from_mem, mem_we  in  1 each  load / store
- has_exception, ecode(6), esubcode(9), exception_maddr(32), ertn  in  upstream exception info
- data_req  out  1  bus request
- data_wr  out  1  write request
- data_size  out  2  0 byte, 1 half, 2 word
- data_wstrb  out  4  byte enables
- data_addr  out  32  request address
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_ok  in  1  response beat
- data_rdata  in  32  response data
- data_ok_out  out  1  filtered data_ok to downstream
- data_from_MEM  out  32  captured own response
- data_valid_from_MEM  out  1  captured data valid
- Registered pass-through outputs, suffixed _out: PC, alu_result, mem_op, res_from_mem, gr_we, dest(5), has_exception, ecode, esubcode, exception_maddr, ertn.

Behaviour:
- Reset is asynchronous. Every output register, counter and flag clears to 0.
- need_mem = in_valid && (res_from_mem || mem_we).
- ale: need_mem with a misaligned access. Half-word access requires addr[0]=1; word access requires addr[1:0]!=0.
- this_flush = in_valid && (has_exception || ale || ertn || RDW_flush).
- data_req = need_mem && !this_flush && !req_sent && !ex_flush && !ertn_flush && discard_cnt==0 && outstanding<MAX_OUTSTANDING.
- req_sent sets on data_req && data_addr_ok. It clears when the instruction advances or on a flush.
- Store wstrb:
  - st.b: 1<<addr[1:0].
  - st.h: 4'b0011<<addr[1:0].
  - st.w: 4'hF.
  - wdata is replicated: byte x4, half x2.
- Loads drive wstrb=0.
- data_addr = alu_result; data_size follows mem_op.
- ready_go = !in_valid || this_flush || !need_mem || req_sent || (data_req && data_addr_ok).
- in_ready = !rst && (!in_valid || (ready_go && out_ready)).
- outstanding: +1 on addr_ok handshake, -1 on data_ok, net 0 on both in the same cycle.
- own_pending: set at this stage's handshake; cleared by its data_ok or by advance.
- Own-data capture: data_ok && discard_cnt==0 && own_pending && outstanding==1. It captures data_rdata into the data buffer, sets data_valid_from_MEM and suppresses data_ok_out for that beat. The buffer clears on advance, and only the advancing cycle transfers it.
- data_ok_out = data_ok && discard_cnt==0 && !own-data capture.
- Flush (ex_flush || ertn_flush):
  - discard_cnt <= outstanding, minus 1 if data_ok fires that cycle.
  - req_sent, own_pending and the data buffer clear.
  - out_valid <= 0.
- While discard_cnt>0, each data_ok decrements it and is swallowed. No new request is issued until it reaches 0.
- Advance (in_valid && ready_go && out_ready): all _out registers load.
  - has_exception_out = has_exception || ale.
  - On ale: ecode_out = 6'h09, esubcode_out = 0, exception_maddr_out = alu_result.
- When out_ready: out_valid <= in_valid && ready_go && !ex_flush && !ertn_flush.
- A request accepted in the same cycle as a flush is counted into discard_cnt.

Test Plan:
- ld.w at 0x1000, addr_ok at cycle 2, out_ready=1 -> one-cycle req with size=2, wstrb=0; advance on the handshake cycle; data_ok_out passes the beat (own_pending already cleared).
- st.b at 0x1003 with store_data=0x000000AB -> wstrb=4'b1000, wdata=0xABABABAB, wr=1.
- ld.h at 0x1001 -> no req, this_flush=1, has_exception_out=1, ecode_out=0x09, exception_maddr_out=0x1001.
- ld.w accepted, out_ready held 0, data_ok with 0xDEADBEEF -> data_ok_out=0; on release data_from_MEM=0xDEADBEEF and data_valid_from_MEM=1 for the advancing transfer.
- Two requests outstanding, then ex_flush -> discard_cnt=2, next two data_ok swallowed, req held low until the count reaches 0.
- Assert rst mid-request -> all outputs 0 immediately, without waiting for a clock edge.
